lpif_txrx_gearbox_master: RTL



---
 rtl/lpif_txrx_gearbox_master.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/lpif_txrx_gearbox_master.sv
// Master-side LPIF gearbox: RATIO beats -> one wide TX word (1 cycle after the last beat), wide RX word -> RATIO beats (1 cycle after accept).
// TX word is held until ready; a word completing into a full, stalled register is dropped and flagged. RX ready only between words.
module lpif_txrx_gearbox_master #(
  parameter int STATE_W   = 4,
  parameter int PROTID_W  = 2,
  parameter int DATA_W    = 128,
  parameter int CRC_W     = 8,
  parameter int MAX_BEATS = 4,
  parameter int BEAT_W    = STATE_W + PROTID_W + DATA_W + CRC_W + 3,
  parameter int WORD_W    = MAX_BEATS * BEAT_W
) (
  input  logic                clk_wr,
  input  logic                rst_wr_n,
  input  logic                m_gen2_mode,
  input  logic [STATE_W-1:0]  dstrm_state,
  input  logic [PROTID_W-1:0] dstrm_protid,
  input  logic [DATA_W-1:0]   dstrm_data,
  input  logic                dstrm_dvalid,
  input  logic [CRC_W-1:0]    dstrm_crc,
  input  logic                dstrm_crc_valid,
  input  logic                dstrm_valid,
  input  logic                tx_flush,
  output logic [WORD_W-1:0]   txfifo_downstream_data,
  output logic                txfifo_downstream_valid,
  input  logic                txfifo_downstream_ready,
  output logic                tx_overflow,
  input  logic [WORD_W-1:0]   rxfifo_upstream_data,
  input  logic                rxfifo_upstream_valid,
  output logic                rxfifo_upstream_ready,
  output logic [STATE_W-1:0]  ustrm_state,
  output logic [PROTID_W-1:0] ustrm_protid,
  output logic [DATA_W-1:0]   ustrm_data,
  output logic                ustrm_dvalid,
  output logic [CRC_W-1:0]    ustrm_crc,
  output logic                ustrm_crc_valid,
  output logic                ustrm_valid
);
  localparam int CNT_W    = $clog2(MAX_BEATS);
  localparam int OFF_PROT = STATE_W;
  localparam int OFF_DATA = OFF_PROT + PROTID_W;
  localparam int OFF_DV   = OFF_DATA + DATA_W;
  localparam int OFF_CRC  = OFF_DV + 1;
  localparam int OFF_CV   = OFF_CRC + CRC_W;
  localparam int OFF_V    = OFF_CV + 1;

  logic              mode_q;
  logic [CNT_W-1:0]  last_idx;
  logic [CNT_W-1:0]  tx_cnt;
  logic [CNT_W-1:0]  rx_cnt;
  logic [WORD_W-1:0] tx_acc;
  logic [WORD_W-1:0] tx_word_nxt;
  logic [WORD_W-1:0] rx_word;
  logic [BEAT_W-1:0] tx_beat;
  logic [BEAT_W-1:0] rx_slot;
  logic              tx_emit;
  logic              rx_busy;
  logic              rx_live;
  logic              rx_last;
  logic              rx_take;

  assign last_idx = mode_q ? CNT_W'(MAX_BEATS - 1) : CNT_W'(MAX_BEATS / 2 - 1);
  assign tx_beat  = {dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid,
                     dstrm_data, dstrm_protid, dstrm_state};

  // Ratio only changes when both directions sit on a word boundary.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      mode_q <= 1'b0;
    end else if (tx_cnt == '0 && !txfifo_downstream_valid && !rx_busy && rx_cnt == '0) begin
      mode_q <= m_gen2_mode;
    end
  end

  always_comb begin
    tx_word_nxt = tx_acc;
    if (dstrm_valid) begin
      tx_word_nxt[int'(tx_cnt)*BEAT_W +: BEAT_W] = tx_beat;
    end
  end

  assign tx_emit = (dstrm_valid && tx_cnt == last_idx) ||
                   (tx_flush && (dstrm_valid || tx_cnt != '0));

  // Accumulator returns to zero on every emit so unfilled slots stay zero.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      tx_acc <= '0;
      tx_cnt <= '0;
    end else if (tx_emit) begin
      tx_acc <= '0;
      tx_cnt <= '0;
    end else if (dstrm_valid) begin
      tx_acc <= tx_word_nxt;
      tx_cnt <= tx_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      txfifo_downstream_data  <= '0;
      txfifo_downstream_valid <= 1'b0;
      tx_overflow             <= 1'b0;
    end else if (tx_emit && txfifo_downstream_valid && !txfifo_downstream_ready) begin
      tx_overflow <= 1'b1;
    end else if (tx_emit) begin
      txfifo_downstream_data  <= tx_word_nxt;
      txfifo_downstream_valid <= 1'b1;
    end else if (txfifo_downstream_ready) begin
      txfifo_downstream_valid <= 1'b0;
    end
  end

  assign rx_last               = rx_busy && rx_cnt == last_idx;
  assign rxfifo_upstream_ready = rx_live && (!rx_busy || rx_last);
  assign rx_take               = rxfifo_upstream_valid && rxfifo_upstream_ready;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      rx_live <= 1'b0;
      rx_busy <= 1'b0;
      rx_cnt  <= '0;
      rx_word <= '0;
    end else begin
      rx_live <= 1'b1;
      rx_busy <= rx_take || (rx_busy && !rx_last);
      rx_cnt  <= (rx_busy && !rx_last) ? rx_cnt + CNT_W'(1) : '0;
      if (rx_take) begin
        rx_word <= rxfifo_upstream_data;
      end
    end
  end

  always_comb begin
    rx_slot = '0;
    if (rx_busy) begin
      rx_slot = rx_word[int'(rx_cnt)*BEAT_W +: BEAT_W];
    end
  end

  assign ustrm_state     = rx_slot[0 +: STATE_W];
  assign ustrm_protid    = rx_slot[OFF_PROT +: PROTID_W];
  assign ustrm_data      = rx_slot[OFF_DATA +: DATA_W];
  assign ustrm_dvalid    = rx_slot[OFF_DV];
  assign ustrm_crc       = rx_slot[OFF_CRC +: CRC_W];
  assign ustrm_crc_valid = rx_slot[OFF_CV];
  assign ustrm_valid     = rx_slot[OFF_V];
endmodule
